// File: rtl/pipe_pkg.sv
// Purpose: shared constants, field type and the passable-gap helper for the pipe scroller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0] field_t;

  // Returns p unchanged unless its low w bits are all ones, in which case
  // bit 0 is cleared so the spawned row always has a passable cell.
  // Operates on a 64-bit carrier so any COLS up to 64 can share it.
  function automatic logic [63:0] gap(input logic [63:0] p, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    gap  = p;
    if ((p & mask) == mask) begin
      gap[0] = 1'b0;
    end
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Purpose: programmable scroll-period counter; tick marks the cycle a scroll step is taken.
// Latency: tick is combinational from the registered count; count updates on the next edge.
// Backpressure: hold freezes the count and masks tick; counting resumes from the held value.
//
// Ports: clock, reset (async active-low), speed_sel (period = TICK_DIV >> speed_sel),
//        hold (pause | crashed), tick (scroll strobe).
module tick_divider #(
  parameter int TICK_DIV = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] speed_sel,
  input  logic       hold,
  output logic       tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;
  logic [CW:0]   period_m1;

  assign period_m1 = (CW+1)'(TICK_DIV >> speed_sel) - (CW+1)'(1);

  // >= rather than == so that switching to a faster speed while the count is
  // already past the new terminal value fires on the next unheld cycle.
  assign tick = ({1'b0, cnt} >= period_m1) & ~hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Purpose: ROWS x COLS pipe field that scrolls one row per tick and spawns LFSR rows every SPAWN_EVERY ticks.
// Latency: tick/spawn combinational from registered state; field, score and crashed update one clock later.
// Backpressure: pause freezes scrolling and all counters; a crash latches until reset and fills the field.
//
// Ports: clock, reset (async active-low), crash, pause, speed_sel, current (candidate row),
//        field (packed, field[r][c]), tick, spawn (LFSR advance), crashed (sticky), score (saturating).
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int TICK_DIV    = 128,
  parameter int SPAWN_EVERY = 4,
  parameter int SCORE_W     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       crash,
  input  logic                       pause,
  input  logic [1:0]                 speed_sel,
  input  logic [COLS-1:0]            current,
  output logic [ROWS-1:0][COLS-1:0]  field,
  output logic                       tick,
  output logic                       spawn,
  output logic                       crashed,
  output logic [SCORE_W-1:0]         score
);

  localparam int SW = (SPAWN_EVERY > 1) ? $clog2(SPAWN_EVERY) : 1;

  logic [SW-1:0]   spcnt;
  logic            spcnt_last;
  logic            shift;
  logic [COLS-1:0] new_row;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .speed_sel (speed_sel),
    .hold      (pause | crashed),
    .tick      (tick)
  );

  assign spcnt_last = (spcnt == SW'(SPAWN_EVERY - 1));
  assign spawn      = tick & spcnt_last;

  // A crash arriving in a tick cycle wins: no shift, no score, no spawn load.
  assign shift   = tick & ~crash;
  assign new_row = spawn ? COLS'(gap(64'(current), COLS)) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      field   <= '0;
      spcnt   <= '0;
      crashed <= 1'b0;
      score   <= '0;
    end else if (crash) begin
      crashed <= 1'b1;
      field   <= '1;
    end else if (shift) begin
      field <= {field[ROWS-2:0], new_row};
      spcnt <= spcnt_last ? '0 : spcnt + 1'b1;
      if ((|field[ROWS-1]) && (score != {SCORE_W{1'b1}})) begin
        score <= score + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Purpose: bench for pipe_scroller with a reference model of the field, counters and score.
// Latency: checks outputs mid-cycle every clock against the model's prediction for that cycle.
// Backpressure: exercises pause hold/resume and the sticky crash.
module tb_pipe_scroller;

  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  localparam int TICK_DIV    = 8;
  localparam int SPAWN_EVERY = 2;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      crash;
  logic                      pause;
  logic [1:0]                speed_sel;
  logic [COLS-1:0]           current;
  logic [ROWS-1:0][COLS-1:0] field, field2;
  logic                      tick, spawn, crashed;
  logic                      tick2, spawn2, crashed2;
  logic [7:0]                score;
  logic [1:0]                score2;

  always #5 clock = ~clock;

  pipe_scroller #(
    .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .SPAWN_EVERY(SPAWN_EVERY), .SCORE_W(8)
  ) dut (
    .clock(clock), .reset(reset), .crash(crash), .pause(pause), .speed_sel(speed_sel),
    .current(current), .field(field), .tick(tick), .spawn(spawn), .crashed(crashed), .score(score)
  );

  pipe_scroller #(
    .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .SPAWN_EVERY(SPAWN_EVERY), .SCORE_W(2)
  ) dut2 (
    .clock(clock), .reset(reset), .crash(crash), .pause(pause), .speed_sel(speed_sel),
    .current(current), .field(field2), .tick(tick2), .spawn(spawn2), .crashed(crashed2), .score(score2)
  );

  // Reference model: rows as a plain array, elapsed clocks since last step,
  // number of steps taken, sticky crash, and an unbounded pass count.
  logic [7:0] m_row [ROWS];
  int         m_cnt;
  int         m_steps;
  bit         m_crashed;
  int         m_passed;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_field();
    logic [63:0] f;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = m_row[r];
    return f;
  endfunction

  function automatic bit m_tick();
    int period;
    period = TICK_DIV >> speed_sel;
    return !pause && !m_crashed && (m_cnt >= period - 1);
  endfunction

  // Every SPAWN_EVERY-th step (the 2nd, 4th, ...) loads a pattern.
  function automatic bit m_spawn();
    return m_tick() && ((m_steps % SPAWN_EVERY) == SPAWN_EVERY - 1);
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) m_row[r] = 8'h00;
    m_cnt = 0; m_steps = 0; m_crashed = 0; m_passed = 0;
  endtask

  // One clock: compare DUT against model for this cycle, then advance both.
  task automatic step();
    bit t, s;
    #1;
    t = m_tick();
    s = m_spawn();
    chk("tick", 64'(tick), 64'(t));
    chk("spawn", 64'(spawn), 64'(s));
    chk("crashed", 64'(crashed), 64'(m_crashed));
    chk("field", 64'(field), m_field());
    chk("score", 64'(score), 64'(sat(m_passed, 255)));
    chk("tick_w2", 64'(tick2), 64'(t));
    chk("field_w2", 64'(field2), m_field());
    chk("score_w2", 64'(score2), 64'(sat(m_passed, 3)));
    @(posedge clock);
    if (crash) begin
      m_crashed = 1;
      for (int r = 0; r < ROWS; r++) m_row[r] = 8'hFF;
    end else if (t) begin
      if (m_row[ROWS-1] != 8'h00) m_passed++;
      for (int r = ROWS - 1; r > 0; r--) m_row[r] = m_row[r-1];
      m_row[0] = !s ? 8'h00 : (current == 8'hFF) ? 8'hFE : current;
      m_steps++;
      m_cnt = 0;
    end else if (!pause && !m_crashed) begin
      m_cnt++;
    end
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b0; crash = 1'b0; pause = 1'b0; speed_sel = 2'd0; current = 8'h04;
    #12;
    chk("rst_field", 64'(field), 64'h0);
    chk("rst_tick", 64'(tick), 64'h0);
    chk("rst_spawn", 64'(spawn), 64'h0);
    chk("rst_crashed", 64'(crashed), 64'h0);
    chk("rst_score", 64'(score), 64'h0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;

    // Eight ticks at period 8: rows alternate 00/04 starting with 00.
    for (int i = 0; i < 7; i++) step();
    #1; chk("first_tick_cycle8", 64'(tick), 64'h1);
    for (int i = 7; i < 64; i++) step();
    chk("field_after_8", 64'(field), 64'h0004_0004_0004_0004);
    chk("score_after_8", 64'(score), 64'h0);
    for (int i = 0; i < 8; i++) step();
    chk("row7_after_9", 64'(field[7]), 64'h04);

    // Tenth tick spawns an all-ones candidate and pushes out the first 04.
    current = 8'hFF;
    for (int i = 0; i < 8; i++) step();
    chk("gap_row0", 64'(field[0]), 64'hFE);
    chk("score_first_pass", 64'(score), 64'h1);

    // Speed change to period 1 while the count sits at 5.
    current = 8'h01;
    for (int i = 0; i < 5; i++) step();
    speed_sel = 2'd3;
    #1; chk("fast_tick_now", 64'(tick), 64'h1);
    for (int i = 0; i < 40; i++) step();
    chk("score_w2_sat", 64'(score2), 64'h3);

    // Pause mid-period at count 3; release should tick after 4 more cycles.
    speed_sel = 2'd0;
    for (int i = 0; i < 3; i++) step();
    pause = 1'b1;
    for (int i = 0; i < 20; i++) step();
    pause = 1'b0;
    n = 0;
    while (n < 20) begin
      #1;
      if (tick === 1'b1) break;
      step();
      n++;
    end
    chk("pause_resume_gap", 64'(n), 64'd4);

    // Crash in the tick cycle: no shift, field fills, tick stays low after.
    crash = 1'b1;
    step();
    crash = 1'b0;
    chk("crash_fill", 64'(field), {64{1'b1}});
    chk("crash_flag", 64'(crashed), 64'h1);
    for (int i = 0; i < 12; i++) step();
    #1; chk("tick_after_crash", 64'(tick), 64'h0);

    // Asynchronous reset in mid-cycle clears everything at once.
    #2 reset = 1'b0;
    #1;
    chk("arst_field", 64'(field), 64'h0);
    chk("arst_crashed", 64'(crashed), 64'h0);
    chk("arst_score", 64'(score), 64'h0);
    chk("arst_tick", 64'(tick), 64'h0);
    chk("arst_spawn", 64'(spawn), 64'h0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    current = 8'h04;
    for (int i = 0; i < 20; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
